// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B, LSB first, one full-subtractor cell
// with a registered borrow. Start/busy/done handshake, WIDTH-bit difference,
// borrow-out and signed-overflow flags, plus a per-bit serial output stream.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow_out,
    output logic             o_overflow,
    output logic             o_diff_bit,
    output logic             o_diff_bit_valid
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_load;
    logic               w_last;

    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [WIDTH-1:0]   r_res;
    logic               r_bor;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_a_msb;
    logic               r_b_msb;

    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow_out;
    logic               r_overflow;
    logic               r_diff_bit_valid;

    logic               w_d;
    logic               w_bor_n;
    logic [WIDTH-1:0]   w_res_n;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and control decode
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_SHIFT;
                    w_load       = 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_next_state = S_DONE;
                    w_last       = 1'b1;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Full-subtractor cell on the current LSBs and the registered borrow
    always_comb begin
        w_d     = r_sa[0] ^ r_sb[0] ^ r_bor;
        w_bor_n = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_bor);
        w_res_n = {w_d, r_res[WIDTH-1:1]};
    end

    // Operand shift registers, result register, borrow and bit counter
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_res   <= '0;
            r_bor   <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else if (w_load) begin
            r_sa    <= i_a;
            r_sb    <= i_b;
            r_bor   <= 1'b0;
            r_cnt   <= '0;
            r_a_msb <= i_a[WIDTH-1];
            r_b_msb <= i_b[WIDTH-1];
        end else if (r_state == S_SHIFT) begin
            r_sa  <= r_sa >> 1;
            r_sb  <= r_sb >> 1;
            r_res <= w_res_n;
            r_bor <= w_bor_n;
            if (!w_last) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Registered handshake and held results; results update only on completion
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_diff_bit_valid <= 1'b0;
            r_diff           <= '0;
            r_borrow_out     <= 1'b0;
            r_overflow       <= 1'b0;
        end else begin
            r_busy           <= (w_next_state == S_SHIFT);
            r_done           <= (w_next_state == S_DONE);
            r_diff_bit_valid <= (w_next_state == S_SHIFT);
            if (w_last) begin
                r_diff       <= w_res_n;
                r_borrow_out <= w_bor_n;
                r_overflow   <= (r_a_msb != r_b_msb) & (w_d != r_a_msb);
            end
        end
    end

    // Output drive; the serial bit is forced low outside SHIFT
    always_comb begin
        o_busy           = r_busy;
        o_done           = r_done;
        o_diff           = r_diff;
        o_borrow_out     = r_borrow_out;
        o_overflow       = r_overflow;
        o_diff_bit_valid = r_diff_bit_valid;
        o_diff_bit       = (r_state == S_SHIFT) ? w_d : 1'b0;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic       i_start;
    logic [7:0] i_a;
    logic [7:0] i_b;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_diff;
    logic       o_borrow_out;
    logic       o_overflow;
    logic       o_diff_bit;
    logic       o_diff_bit_valid;

    int n_assert = 0;
    int n_fail   = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .i_clk           (clk),
        .i_rst_n         (i_rst_n),
        .i_start         (i_start),
        .i_a             (i_a),
        .i_b             (i_b),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_diff          (o_diff),
        .o_borrow_out    (o_borrow_out),
        .o_overflow      (o_overflow),
        .o_diff_bit      (o_diff_bit),
        .o_diff_bit_valid(o_diff_bit_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Arithmetic reference: {overflow, borrow, diff}
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] d;
        logic       bo;
        logic       ov;
        d  = a - b;
        bo = (a < b);
        ov = (a[7] != b[7]) && (d[7] != a[7]);
        return {ov, bo, d};
    endfunction

    // One full operation from IDLE: latency, busy length, serial stream, results
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ediff, input logic ebor, input logic eovf,
                          input string tag);
        logic [7:0] stream;
        int lat;
        int busy_n;
        int nb;
        stream = '0;
        lat    = 0;
        busy_n = 0;
        nb     = 0;
        i_a     = a;
        i_b     = b;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        while (!o_done && lat < 20) begin
            if (o_busy) busy_n++;
            if (o_diff_bit_valid) begin
                stream = {o_diff_bit, stream[7:1]};
                nb++;
            end
            step();
            lat++;
        end
        check({tag, ".latency"}, lat, 8);
        check({tag, ".busy_cycles"}, busy_n, 8);
        check({tag, ".bits"}, nb, 8);
        check({tag, ".done"}, o_done, 1);
        check({tag, ".busy_in_done"}, o_busy, 0);
        check({tag, ".diff"}, o_diff, ediff);
        check({tag, ".borrow"}, o_borrow_out, ebor);
        check({tag, ".overflow"}, o_overflow, eovf);
        check({tag, ".stream"}, stream, ediff);
        step();
        check({tag, ".done_pulse"}, o_done, 0);
        check({tag, ".diff_held"}, o_diff, ediff);
    endtask

    initial begin
        logic [7:0] got;
        logic [7:0] cap_a [3];
        logic [7:0] cap_b [3];
        logic [7:0] drv_a;
        logic [7:0] drv_b;
        logic [9:0] m;
        logic       prev_busy;
        int busy_n;
        int dones;
        int nacc;
        int last_c;
        int c;

        i_rst_n = 1'b0;
        i_start = 1'b0;
        i_a     = '0;
        i_b     = '0;
        step();
        step();
        check("rst.busy", o_busy, 0);
        check("rst.done", o_done, 0);
        check("rst.diff", o_diff, 0);
        check("rst.borrow", o_borrow_out, 0);
        check("rst.overflow", o_overflow, 0);
        check("rst.dbv", o_diff_bit_valid, 0);
        check("rst.dbit", o_diff_bit, 0);
        i_rst_n = 1'b1;
        step();

        // Directed vectors, hand-computed
        run_op(8'h5A, 8'h21, 8'h39, 1'b0, 1'b0, "d5a_21");
        run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, "d10_20");
        run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "d00_00");
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "d80_01");
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "d7f_ff");

        // start and operand changes during SHIFT are ignored
        i_a     = 8'h33;
        i_b     = 8'h11;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        busy_n  = 0;
        dones   = 0;
        got     = '0;
        for (int k = 1; k <= 14; k++) begin
            if (o_busy) busy_n++;
            if (o_done) begin
                dones++;
                got = o_diff;
            end
            if (k == 3) begin
                i_start = 1'b1;
                i_a     = 8'hFF;
                i_b     = 8'h00;
            end else begin
                i_start = 1'b0;
                i_a     = 8'($urandom);
                i_b     = 8'($urandom);
            end
            step();
        end
        check("mid.diff", got, 8'h22);
        check("mid.dones", dones, 1);
        check("mid.busy_cycles", busy_n, 8);

        // Reset mid-SHIFT aborts and clears held results
        run_op(8'h5A, 8'h21, 8'h39, 1'b0, 1'b0, "pre_rst");
        i_a     = 8'h10;
        i_b     = 8'h01;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        step();
        step();
        step();
        i_rst_n = 1'b0;
        step();
        check("abort.busy", o_busy, 0);
        check("abort.done", o_done, 0);
        check("abort.diff", o_diff, 0);
        check("abort.borrow", o_borrow_out, 0);
        check("abort.overflow", o_overflow, 0);
        check("abort.dbv", o_diff_bit_valid, 0);
        check("abort.dbit", o_diff_bit, 0);
        i_rst_n = 1'b1;
        dones   = 0;
        busy_n  = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (o_done) dones++;
            if (o_busy) busy_n++;
        end
        check("abort.no_done", dones, 0);
        check("abort.idle", busy_n, 0);
        run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, "post_rst");

        // start held high: back-to-back operations
        i_start   = 1'b1;
        prev_busy = o_busy;
        dones     = 0;
        nacc      = 0;
        last_c    = 0;
        c         = 0;
        while (c < 80 && dones < 3) begin
            drv_a = 8'($urandom);
            drv_b = 8'($urandom);
            i_a   = drv_a;
            i_b   = drv_b;
            step();
            c++;
            if (o_busy && !prev_busy && nacc < 3) begin
                cap_a[nacc] = drv_a;
                cap_b[nacc] = drv_b;
                nacc++;
            end
            if (o_done) begin
                m = model(cap_a[dones], cap_b[dones]);
                check("b2b.diff", o_diff, m[7:0]);
                check("b2b.borrow", o_borrow_out, m[8]);
                check("b2b.overflow", o_overflow, m[9]);
                if (dones > 0) check("b2b.spacing", c - last_c, 10);
                last_c = c;
                dones++;
                if (dones == 3) i_start = 1'b0;
            end
            prev_busy = o_busy;
        end
        check("b2b.count", dones, 3);
        i_start = 1'b0;
        step();
        step();

        // Random operands against the arithmetic model
        for (int k = 0; k < 1000; k++) begin
            drv_a = 8'($urandom);
            drv_b = 8'($urandom);
            m     = model(drv_a, drv_b);
            run_op(drv_a, drv_b, m[7:0], m[8], m[9], "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
